// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer that shares one data-memory port between
// the load/store unit (port 0) and the debug/DMA port (port 1).
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [DATA_W-1:0] WDATA0,
  output logic              GNT0,
  output logic              ACK0,
  output logic [DATA_W-1:0] RDATA0,
  input  logic              REQ1,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] WDATA1,
  output logic              GNT1,
  output logic              ACK1,
  output logic [DATA_W-1:0] RDATA1,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_D_IN,
  input  logic [DATA_W-1:0] MEM_D_OUT
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              win_q, win_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;

  req_t              req_pl0, req_pl1, sel_pl;
  logic              sel_id;

  assign req_pl0 = {WE0, ADDR0, WDATA0};
  assign req_pl1 = {WE1, ADDR1, WDATA1};

  // Next-state and next-output logic; GNT/ACK/MEM_WE default to a single-cycle pulse.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cnt_d      = cnt_q;
    gnt_d      = 2'b00;
    ack_d      = 2'b00;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    mem_addr_d = mem_addr_q;
    mem_we_d   = 1'b0;
    mem_din_d  = mem_din_q;
    sel_id     = 1'b0;
    sel_pl     = req_pl0;

    case (state_q)
      S_IDLE: begin
        if (REQ0 || REQ1) begin
          sel_id        = (REQ0 && REQ1) ? ptr_q : REQ1;
          sel_pl        = sel_id ? req_pl1 : req_pl0;
          mem_addr_d    = sel_pl.addr;
          mem_we_d      = sel_pl.we;
          mem_din_d     = sel_pl.wdata;
          win_d         = sel_id;
          gnt_d[sel_id] = 1'b1;
          ptr_d         = ~sel_id;
          state_d       = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (mem_we_q) begin
          ack_d[win_q] = 1'b1;
          state_d      = S_RESP;
        end else if (RD_LAT == 0) begin
          if (win_q) rdata1_d = MEM_D_OUT;
          else       rdata0_d = MEM_D_OUT;
          ack_d[win_q] = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d   = CNT_W'(RD_LAT - 1);
          state_d = S_WAIT;
        end
      end

      // MEM_ADDR stays put while the memory pipeline drains.
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (win_q) rdata1_d = MEM_D_OUT;
          else       rdata0_d = MEM_D_OUT;
          ack_d[win_q] = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      win_q      <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= 2'b00;
      ack_q      <= 2'b00;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      mem_addr_q <= '0;
      mem_we_q   <= 1'b0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      mem_addr_q <= mem_addr_d;
      mem_we_q   <= mem_we_d;
      mem_din_q  <= mem_din_d;
    end
  end

  assign GNT0     = gnt_q[0];
  assign GNT1     = gnt_q[1];
  assign ACK0     = ack_q[0];
  assign ACK1     = ack_q[1];
  assign RDATA0   = rdata0_q;
  assign RDATA1   = rdata1_q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_WE   = mem_we_q;
  assign MEM_D_IN = mem_din_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-timeline model compared every cycle,
// directed scenarios with literal expectations, and RD_LAT=0/3 latency builds.
module tb_dmem_arbiter;

  localparam int unsigned AW  = 5;
  localparam int unsigned DW  = 64;
  localparam int unsigned LAT = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_din, mem_dout;
  logic          gnt0, ack0, gnt1, ack1, mem_we;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ0(req0), .WE0(we0), .ADDR0(addr0), .WDATA0(wdata0),
    .GNT0(gnt0), .ACK0(ack0), .RDATA0(rdata0),
    .REQ1(req1), .WE1(we1), .ADDR1(addr1), .WDATA1(wdata1),
    .GNT1(gnt1), .ACK1(ack1), .RDATA1(rdata1),
    .MEM_ADDR(mem_addr), .MEM_WE(mem_we), .MEM_D_IN(mem_din), .MEM_D_OUT(mem_dout)
  );

  // Memory with one-cycle registered read.
  logic [DW-1:0] mem [32];
  logic [DW-1:0] rd_pipe;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    rd_pipe <= mem[mem_addr];
  end
  assign mem_dout = rd_pipe;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: a transaction is a timeline of k = 1..ack_k cycles after the selecting edge.
  logic [DW-1:0] ref_mem [32];
  int            m_k = 0;
  int            m_ack_k = 2;
  logic          m_win, m_ptr, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, e_rdata0, e_rdata1;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_k = 0; m_ptr = 1'b0; m_win = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; e_rdata0 = '0; e_rdata1 = '0;
    end else if (m_k == 0) begin
      if (req0 || req1) begin
        m_win   = (req0 && req1) ? m_ptr : req1;
        m_we    = m_win ? we1 : we0;
        m_addr  = m_win ? addr1 : addr0;
        m_wdata = m_win ? wdata1 : wdata0;
        m_ptr   = !m_win;
        m_ack_k = (m_we || LAT == 0) ? 2 : 2 + int'(LAT);
        m_k     = 1;
      end
    end else begin
      if (m_k == 1 && m_we) ref_mem[m_addr] = m_wdata;
      if (m_k == m_ack_k) m_k = 0;
      else m_k++;
      if (m_k != 0 && m_k == m_ack_k && !m_we) begin
        if (m_win) e_rdata1 = ref_mem[m_addr];
        else       e_rdata0 = ref_mem[m_addr];
      end
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("gnt0", 64'(gnt0), 64'(m_k == 1 && !m_win));
      chk("gnt1", 64'(gnt1), 64'(m_k == 1 && m_win));
      chk("ack0", 64'(ack0), 64'(m_k != 0 && m_k == m_ack_k && !m_win));
      chk("ack1", 64'(ack1), 64'(m_k != 0 && m_k == m_ack_k && m_win));
      chk("mem_we", 64'(mem_we), 64'(m_k == 1 && m_we));
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("mem_d_in", mem_din, m_wdata);
      chk("rdata0", rdata0, e_rdata0);
      chk("rdata1", rdata1, e_rdata1);
    end
  end

  // Event monitors used by the directed checks.
  int gnt_log[$];
  int gnt_cyc0[$];
  int lg0 = 0, lg1 = 0, la0 = 0, la1 = 0;
  int ack_cnt0 = 0, ack_cnt1 = 0, we_cnt = 0, we_double = 0;
  logic we_prev = 1'b0;
  always @(negedge clk) begin
    if (gnt0) begin gnt_log.push_back(0); gnt_cyc0.push_back(cyc); lg0 = cyc; end
    if (gnt1) begin gnt_log.push_back(1); lg1 = cyc; end
    if (ack0) begin ack_cnt0++; la0 = cyc; end
    if (ack1) begin ack_cnt1++; la1 = cyc; end
    if (mem_we) we_cnt++;
    if (mem_we && we_prev) we_double++;
    we_prev = mem_we;
  end

  // Requester drivers: hold REQ and payload until GNT, then load the next op or drop REQ.
  typedef struct packed {
    logic          glitch;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } op_t;
  op_t q0[$], q1[$];

  task automatic push(input int port, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input logic gl);
    op_t op;
    op.glitch = gl; op.we = we; op.addr = a; op.wdata = d;
    if (port == 0) q0.push_back(op);
    else q1.push_back(op);
  endtask

  initial begin
    op_t  op;
    logic g0f, g1f;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    forever begin
      @(negedge clk);
      g0f = 1'b0; g1f = 1'b0;
      if (rst_n) begin
        if (req0 && gnt0) req0 = 1'b0;
        if (req1 && gnt1) req1 = 1'b0;
        if (!req0 && q0.size() > 0) begin
          op = q0.pop_front();
          we0 = op.we; addr0 = op.addr; wdata0 = op.wdata; req0 = 1'b1; g0f = op.glitch;
        end
        if (!req1 && q1.size() > 0) begin
          op = q1.pop_front();
          we1 = op.we; addr1 = op.addr; wdata1 = op.wdata; req1 = 1'b1; g1f = op.glitch;
        end
        // A glitched request is withdrawn long before the next sampling edge.
        if (g0f || g1f) begin
          #1;
          if (g0f) req0 = 1'b0;
          if (g1f) req1 = 1'b0;
        end
      end
    end
  end

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || req0 || req1 || m_k != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk({name, "_timeout"}, 64'(n), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // RD_LAT=0 and RD_LAT=3 builds, each reading addr 31 through port 1.
  int sub_done = 0;
  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int unsigned L    = (g == 0) ? 0 : 3;
    localparam int unsigned PIDX = (g == 0) ? 0 : 2;
    logic          s_req1, s_gnt0, s_gnt1, s_ack0, s_ack1, s_mwe;
    logic [AW-1:0] s_maddr;
    logic [DW-1:0] s_rd0, s_rd1, s_mdin, s_mdout, s_val;
    logic [DW-1:0] s_pipe [3];

    assign s_val = (s_maddr == 5'd31) ? {DW{1'b1}} : DW'(s_maddr);
    always @(posedge clk) begin
      s_pipe[0] <= s_val;
      s_pipe[1] <= s_pipe[0];
      s_pipe[2] <= s_pipe[1];
    end
    assign s_mdout = (L == 0) ? s_val : s_pipe[PIDX];

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) dut_l (
      .CLK(clk), .RST_N(rst_n),
      .REQ0(1'b0), .WE0(1'b0), .ADDR0(5'd0), .WDATA0(64'd0),
      .GNT0(s_gnt0), .ACK0(s_ack0), .RDATA0(s_rd0),
      .REQ1(s_req1), .WE1(1'b0), .ADDR1(5'd31), .WDATA1(64'd0),
      .GNT1(s_gnt1), .ACK1(s_ack1), .RDATA1(s_rd1),
      .MEM_ADDR(s_maddr), .MEM_WE(s_mwe), .MEM_D_IN(s_mdin), .MEM_D_OUT(s_mdout)
    );

    initial begin : run
      int n;
      s_req1 = 1'b0;
      wait (rst_n === 1'b1);
      @(negedge clk);
      s_req1 = 1'b1;
      n = 0;
      while (!s_ack1 && n < 20) begin
        @(negedge clk);
        n++;
        if (s_gnt1) s_req1 = 1'b0;
      end
      chk($sformatf("lat%0d_ack_cycles", L), 64'(n), (L == 0) ? 64'd2 : 64'(2 + L));
      chk($sformatf("lat%0d_rdata1", L), s_rd1, {DW{1'b1}});
      chk($sformatf("lat%0d_rdata0", L), s_rd0, 64'd0);
      chk($sformatf("lat%0d_mem_we", L), 64'(s_mwe), 64'd0);
      sub_done++;
    end
  end

  initial begin
    int n, g0, w0, a0, a1, gs;
    for (int i = 0; i < 32; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    mem[3] = 64'd7;  ref_mem[3] = 64'd7;
    mem[4] = 64'd9;  ref_mem[4] = 64'd9;
    mem[31] = {DW{1'b1}}; ref_mem[31] = {DW{1'b1}};

    rst_n = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_gnt0", 64'(gnt0), 64'd0);
    chk("rst_ack1", 64'(ack1), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rdata0", rdata0, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then cross-port readback.
    push(0, 1'b1, 5'd11, 64'd150, 1'b0);
    wait_quiet("t1w");
    chk("t1_mem11", mem[11], 64'd150);
    chk("t1_wr_lat", 64'(la0 - lg0), 64'd1);
    chk("t1_we_cnt", 64'(we_cnt), 64'd1);
    push(1, 1'b0, 5'd11, 64'd0, 1'b0);
    wait_quiet("t1r");
    chk("t1_rdata1", rdata1, 64'd150);
    chk("t1_rdata0", rdata0, 64'd0);
    chk("t1_rd_lat", 64'(la1 - lg1), 64'd2);

    // Simultaneous requests with the pointer at 0, twice.
    g0 = gnt_log.size();
    push(0, 1'b0, 5'd3, 64'd0, 1'b0);
    push(1, 1'b0, 5'd4, 64'd0, 1'b0);
    wait_quiet("t2a");
    chk("t2a_rdata0", rdata0, 64'd7);
    chk("t2a_rdata1", rdata1, 64'd9);
    push(1, 1'b0, 5'd3, 64'd0, 1'b0);
    push(0, 1'b0, 5'd4, 64'd0, 1'b0);
    wait_quiet("t2b");
    chk("t2b_rdata0", rdata0, 64'd9);
    chk("t2b_rdata1", rdata1, 64'd7);
    chk("t2_ngnt", 64'(gnt_log.size() - g0), 64'd4);
    chk("t2_order0", 64'(gnt_log[g0]), 64'd0);
    chk("t2_order1", 64'(gnt_log[g0+1]), 64'd1);
    chk("t2_order2", 64'(gnt_log[g0+2]), 64'd0);
    chk("t2_order3", 64'(gnt_log[g0+3]), 64'd1);

    // One real write, one withdrawn request; pointer then favours port 1.
    w0 = we_cnt;
    push(0, 1'b1, 5'd11, 64'd300, 1'b0);
    wait_quiet("t3a");
    push(0, 1'b1, 5'd11, 64'd300, 1'b1);
    wait_quiet("t3b");
    chk("t3_we_cnt", 64'(we_cnt - w0), 64'd1);
    g0 = gnt_log.size();
    push(0, 1'b0, 5'd11, 64'd0, 1'b0);
    push(1, 1'b0, 5'd3, 64'd0, 1'b0);
    wait_quiet("t3c");
    chk("t3_rdata0", rdata0, 64'd300);
    chk("t3_rdata1", rdata1, 64'd7);
    chk("t3_order0", 64'(gnt_log[g0]), 64'd1);
    chk("t3_order1", 64'(gnt_log[g0+1]), 64'd0);

    // Top address, RD_LAT=1 build.
    push(1, 1'b0, 5'd31, 64'd0, 1'b0);
    wait_quiet("t4");
    chk("t4_rdata1", rdata1, {DW{1'b1}});
    chk("t4_rd_lat", 64'(la1 - lg1), 64'd2);

    // Back-to-back writes with REQ0 held.
    gs = gnt_cyc0.size(); w0 = we_cnt; a0 = ack_cnt0;
    for (int i = 0; i < 4; i++) push(0, 1'b1, AW'(i), 64'h100 + 64'(i), 1'b0);
    wait_quiet("t6");
    chk("t6_acks", 64'(ack_cnt0 - a0), 64'd4);
    chk("t6_writes", 64'(we_cnt - w0), 64'd4);
    for (int i = 1; i < 4; i++)
      chk($sformatf("t6_spacing%0d", i), 64'(gnt_cyc0[gs+i] - gnt_cyc0[gs+i-1]), 64'd3);
    for (int i = 0; i < 4; i++)
      chk($sformatf("t6_mem%0d", i), mem[i], 64'h100 + 64'(i));
    chk("t6_we_overlap", 64'(we_double), 64'd0);

    n = 0;
    while (sub_done < 2 && n < 100) begin @(negedge clk); n++; end
    if (sub_done < 2) chk("sub_done", 64'(sub_done), 64'd2);

    // Reset during WAIT of a port-1 read.
    a1 = ack_cnt1;
    push(1, 1'b0, 5'd4, 64'd0, 1'b0);
    n = 0;
    while (!gnt1 && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("t5_gnt1_timeout", 64'(n), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_ack1", 64'(ack1), 64'd0);
    chk("t5_gnt1", 64'(gnt1), 64'd0);
    chk("t5_mem_we", 64'(mem_we), 64'd0);
    chk("t5_mem_addr", 64'(mem_addr), 64'd0);
    chk("t5_rdata1", rdata1, 64'd0);
    chk("t5_rdata0", rdata0, 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_no_ack", 64'(ack_cnt1 - a1), 64'd0);
    g0 = gnt_log.size();
    push(0, 1'b0, 5'd0, 64'd0, 1'b0);
    push(1, 1'b0, 5'd4, 64'd0, 1'b0);
    wait_quiet("t5b");
    chk("t5_order0", 64'(gnt_log[g0]), 64'd0);
    chk("t5_order1", 64'(gnt_log[g0+1]), 64'd1);
    chk("t5_rdata0b", rdata0, 64'h100);
    chk("t5_rdata1b", rdata1, 64'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 32x64-bit data memory (5-bit address, write-enable, 64-bit write/read data).
- Shares the single memory port between requester 0 (load/store unit) and requester 1 (debug/DMA port).
- Uses round-robin priority, a req/gnt/ack handshake, and a fixed, parameterised read-capture latency.
- Sits between the core datapath and the memory instance; the memory sees exactly one access at a time.

Parameters:
- ADDR_W, 5, memory address width.
- DATA_W, 64, memory data width.
- RD_LAT, 1, number of cycles from the address-presenting edge to the edge that samples MEM_D_out. Legal range 0..3. 0 means combinational memory read.

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST_N  input  1  synchronous reset, active-low
- REQ0  input  1  requester 0 access request, held until GNT0 seen
- WE0  input  1  requester 0 write (1) / read (0)
- ADDR0  input  ADDR_W  requester 0 address
- WDATA0  input  DATA_W  requester 0 write data
- GNT0  output  1  one-cycle grant pulse to requester 0
- ACK0  output  1  one-cycle completion pulse to requester 0
- RDATA0  output  DATA_W  read data for requester 0, valid while ACK0=1
- REQ1, WE1, ADDR1, WDATA1, GNT1, ACK1, RDATA1  same as above, for requester 1
- MEM_ADDR  output  ADDR_W  memory address
- MEM_WE  output  1  memory write enable
- MEM_D_IN  output  DATA_W  memory write data
- MEM_D_OUT  input  DATA_W  memory read data

Behaviour:
- Reset (RST_N=0 at a rising edge):
  - State goes to IDLE; priority pointer PTR=0.
  - All outputs are 0: GNTx, ACKx, RDATAx, MEM_ADDR, MEM_WE, MEM_D_IN.
  - A reset mid-operation aborts the access: no ACK is issued, and MEM_WE is 0 from the next edge onward.
- States and transitions:
  - IDLE: samples REQ0/REQ1.
    - Neither asserted: stay in IDLE.
    - One asserted: select it.
    - Both asserted: select the requester equal to PTR.
    - On selection, at the same edge:
      - latch WE/ADDR/WDATA of the winner into MEM_WE/MEM_ADDR/MEM_D_IN;
      - register the winner id;
      - set GNTwinner=1;
      - PTR <= other requester;
      - go to ACCESS.
  - ACCESS (1 cycle): GNT is high and MEM_* are driven; the memory performs the write at the closing edge. At that edge:
    - GNT <= 0;
    - MEM_WE <= 0;
    - for a write, go to RESP;
    - for a read with RD_LAT=0, capture MEM_D_OUT into the winner's RDATA and go to RESP;
    - otherwise load the wait counter with RD_LAT-1 and go to WAIT.
  - WAIT: MEM_ADDR is held stable.
    - Counter decrements each edge.
    - At the edge where the counter is 0, capture MEM_D_OUT into RDATAwinner and go to RESP.
  - RESP (1 cycle): ACKwinner=1. At the closing edge, ACK <= 0 and go to IDLE.
- Latency from REQ sampled to ACK high: write 2 cycles; read 2+RD_LAT cycles (RD_LAT>=1), 2 cycles when RD_LAT=0.
  - Minimum issue interval: 3 cycles for writes, 3+RD_LAT for reads.
- Handshake rules:
  - A requester keeps REQ and its payload stable until it samples GNT=1, then deasserts REQ. Payload may change after GNT.
  - REQ still high when the arbiter returns to IDLE is treated as a new request.
- RDATAx holds its last captured value until the next read completes for that requester. Writes do not modify RDATAx.
- The non-selected requester's GNT/ACK stay 0. A pending REQ is not dropped; it wins at the next IDLE because PTR points to it.
- The arbiter never asserts MEM_WE outside ACCESS. MEM_WE is exactly one cycle per write.
- No address-range checking; full ADDR_W range is valid. Addresses 0 and 31 pass through unchanged.

Test Plan:
1. Reset, then REQ0 write ADDR0=11 WDATA0=150 -> GNT0 pulse in ACCESS, MEM_WE=1 for exactly 1 cycle with MEM_ADDR=11, ACK0 two cycles after sampling. Then REQ1 read ADDR1=11 -> ACK1 with RDATA1=150, RDATA0 unchanged (0).
2. REQ0 and REQ1 both held, reads of addr 3 (mem=7) and addr 4 (mem=9), from reset -> port 0 served first (RDATA0=7), then port 1 (RDATA1=9). Repeating the pair in the opposite order still alternates grants.
3. Write 300 to addr 11 by port 0 with WE asserted only through ACCESS; a second write of 300 with REQ dropped before sampling -> exactly one memory write; readback 300.
4. RD_LAT=0, 1, 3 builds, read addr 31 (mem=0xFFFF_FFFF_FFFF_FFFF) -> ACK at 2, 3, 5 cycles after request sampling; RDATA correct in each build.
5. RST_N=0 asserted during WAIT of a port 1 read -> no ACK1, all outputs 0 after that edge, PTR=0. Afterwards a simultaneous request grants port 0 first.
6. Back-to-back: REQ0 held high across 4 writes to addrs 0..3 -> four GNT0/ACK0 pairs, 3-cycle spacing, no overlap of MEM_WE pulses.
